// File: rtl/synchronous_fifo_arbiter_pkg.sv
// rtl/synchronous_fifo_arbiter_pkg.sv - shared types and helpers for the FIFO push arbiter
package synchronous_fifo_arbiter_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

   function automatic int idx_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin first-set picker starting at rrPtr
module rr_priority_picker
   import synchronous_fifo_arbiter_pkg::*;
#(
   parameter  int M  = 4,
   localparam int IW = idx_width(M)
) (
   input  logic [M-1:0]  req,
   input  logic [IW-1:0] rrPtr,
   output logic          valid,
   output logic [IW-1:0] index
);

   logic [2*M-1:0] dbl;
   logic [M-1:0]   rot;
   int             pos;

   // Rotating the doubled vector puts rrPtr at bit 0, so the lowest set bit is the winner.
   always_comb begin
      dbl   = {req, req};
      rot   = M'(dbl >> rrPtr);
      valid = 1'b0;
      index = '0;
      pos   = 0;
      for (int k = M - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            pos   = int'(rrPtr) + k;
            if (pos >= M) pos = pos - M;
            index = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/synchronous_fifo_push_arbiter.sv
// rtl/synchronous_fifo_push_arbiter.sv - packet-locking round-robin arbiter for a shared FIFO push port
module synchronous_fifo_push_arbiter
   import synchronous_fifo_arbiter_pkg::*;
#(
   parameter  int N  = 32,
   parameter  int M  = 4,
   parameter  int CW = 16,
   localparam int IW = idx_width(M)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [M-1:0]  req,
   input  logic [M*N-1:0] reqData,
   input  logic [M-1:0]  reqLast,
   output logic [M-1:0]  gnt,
   output logic          push,
   output logic [N-1:0]  pushData,
   input  logic          full,
   output logic [IW-1:0] owner,
   output logic          locked,
   output logic [M*CW-1:0] wordCount,
   output logic          protocolError
);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic          perr_q, perr_d;
   logic [CW-1:0] cnt_q [M];

   logic          pick_valid;
   logic [IW-1:0] pick_idx;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (int'(i) == M - 1) ? '0 : i + 1'b1;
   endfunction

   rr_priority_picker #(.M(M)) u_picker (
      .req   (req),
      .rrPtr (rr_ptr_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         perr_q   <= 1'b0;
         for (int i = 0; i < M; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         perr_q   <= perr_d;
         for (int i = 0; i < M; i++) begin
            if (gnt[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      perr_d   = perr_q;
      case (state_q)
         IDLE: begin
            if (push) begin
               if (reqLast[pick_idx]) begin
                  rr_ptr_d = next_idx(pick_idx);
               end else begin
                  state_d = LOCKED;
                  owner_d = pick_idx;
               end
            end
         end
         LOCKED: begin
            if (push && reqLast[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_idx(owner_q);
            end
            if (!req[owner_q]) perr_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are qualified by rstn so the push port is quiet for the whole reset window.
   always_comb begin
      gnt = '0;
      if (rstn) begin
         if (state_q == IDLE) begin
            if (pick_valid && !full) gnt[pick_idx] = 1'b1;
         end else begin
            gnt[owner_q] = req[owner_q] & ~full;
         end
      end
      push     = |gnt;
      pushData = '0;
      for (int i = 0; i < M; i++) begin
         if (gnt[i]) pushData = reqData[i*N +: N];
      end
   end

   always_comb begin
      wordCount = '0;
      for (int i = 0; i < M; i++) wordCount[i*CW +: CW] = cnt_q[i];
   end

   assign owner         = owner_q;
   assign locked        = (state_q == LOCKED);
   assign protocolError = perr_q;

endmodule
